// File: rtl/uart_boot_loader.sv
// UART boot loader for a 16-bit PicoBlaze-style core.
//
// Receives a framed program image over a UART byte stream:
//   0xA5 | N[15:8] | N[7:0] | {hi, lo} x N | xor-checksum
// Each word is written to instruction memory from address 0 upward. The
// frame is then answered with ACK (0x06) or NAK (0x15). The CPU is held in
// reset for the whole load and is released only after a verified image.
//
// Ports:
//   SYS_CLK      system clock, all logic on the rising edge
//   SYS_RST      synchronous active-high reset
//   i_RX_DATA    received byte, qualified by i_RX_VALID
//   i_RX_VALID   one-cycle receive strobe
//   i_BOOT_REQ   level request to reload the program (honoured in RUN only)
//   i_TX_BUSY    transmitter busy; the reply waits while it is high
//   o_TX_DATA    reply byte
//   o_TX_START   one-cycle transmit strobe
//   o_CPU_RST    holds the core in reset outside RUN
//   o_IMEM_WE    one-cycle instruction-memory write enable
//   o_IMEM_ADDR  instruction-memory write address
//   o_IMEM_DATA  instruction word
//   o_BOOT_DONE  high while the core runs a verified image
//   o_ERR        sticky error, cleared by a good load or reset
module uart_boot_loader #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter bit          BOOT_ON_RST = 1'b1
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic [7:0]        i_RX_DATA,
  input  logic              i_RX_VALID,
  input  logic              i_BOOT_REQ,
  input  logic              i_TX_BUSY,
  output logic [7:0]        o_TX_DATA,
  output logic              o_TX_START,
  output logic              o_CPU_RST,
  output logic              o_IMEM_WE,
  output logic [ADDR_W-1:0] o_IMEM_ADDR,
  output logic [15:0]       o_IMEM_DATA,
  output logic              o_BOOT_DONE,
  output logic              o_ERR
);

  // Word count and address counter carry one extra bit so a full
  // 2^ADDR_W-word image can be counted without wrapping.
  localparam int unsigned LenW = ADDR_W + 1;
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [7:0] SyncByte = 8'hA5;
  localparam logic [7:0] AckByte  = 8'h06;
  localparam logic [7:0] NakByte  = 8'h15;

  typedef enum logic [2:0] {
    StRun,
    StSync,
    StLenHi,
    StLenLo,
    StDatHi,
    StDatLo,
    StChk,
    StReply
  } state_e;

  state_e            state_q;
  logic [7:0]        len_hi_q;
  logic [LenW-1:0]   len_q;
  logic [LenW-1:0]   cnt_q;
  logic [7:0]        hi_q;
  logic [7:0]        chk_q;
  logic              ack_q;
  logic [TmoW-1:0]   tmo_q;
  logic [7:0]        tx_data_q;
  logic              tx_start_q;
  logic              cpu_rst_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [15:0]       imem_data_q;
  logic              boot_done_q;
  logic              err_q;

  logic [15:0]     len_word;
  logic            len_bad;
  logic [LenW-1:0] cnt_inc;
  logic            load_active;
  logic            tmo_hit;

  always_comb begin
    len_word    = {len_hi_q, i_RX_DATA};
    len_bad     = (len_word == 16'd0) || (32'(len_word) > (32'd1 << ADDR_W));
    cnt_inc     = cnt_q + LenW'(1);
    // The inter-byte timeout only watches the frame body, not SYNC or REPLY.
    load_active = (state_q == StLenHi) || (state_q == StLenLo) ||
                  (state_q == StDatHi) || (state_q == StDatLo) ||
                  (state_q == StChk);
    tmo_hit     = load_active && !i_RX_VALID && (tmo_q == TmoW'(TIMEOUT - 1));
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q     <= BOOT_ON_RST ? StSync : StRun;
      len_hi_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      chk_q       <= '0;
      ack_q       <= 1'b0;
      tmo_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      cpu_rst_q   <= BOOT_ON_RST;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      boot_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      imem_we_q  <= 1'b0;
      tx_start_q <= 1'b0;

      if (load_active && !i_RX_VALID) begin
        tmo_q <= tmo_q + TmoW'(1);
      end else begin
        tmo_q <= '0;
      end

      if (tmo_hit) begin
        // Abandon the frame silently; the host must resend from the header.
        state_q     <= StSync;
        err_q       <= 1'b1;
        boot_done_q <= 1'b0;
      end else begin
        unique case (state_q)
          StRun: begin
            if (i_BOOT_REQ) begin
              state_q     <= StSync;
              cpu_rst_q   <= 1'b1;
              boot_done_q <= 1'b0;
            end
          end
          StSync: begin
            if (i_RX_VALID && (i_RX_DATA == SyncByte)) begin
              state_q <= StLenHi;
            end
          end
          StLenHi: begin
            if (i_RX_VALID) begin
              len_hi_q <= i_RX_DATA;
              state_q  <= StLenLo;
            end
          end
          StLenLo: begin
            if (i_RX_VALID) begin
              cnt_q <= '0;
              chk_q <= '0;
              if (len_bad) begin
                ack_q   <= 1'b0;
                state_q <= StReply;
              end else begin
                len_q   <= LenW'(len_word);
                state_q <= StDatHi;
              end
            end
          end
          StDatHi: begin
            if (i_RX_VALID) begin
              hi_q    <= i_RX_DATA;
              chk_q   <= chk_q ^ i_RX_DATA;
              state_q <= StDatLo;
            end
          end
          StDatLo: begin
            if (i_RX_VALID) begin
              imem_we_q   <= 1'b1;
              imem_addr_q <= cnt_q[ADDR_W-1:0];
              imem_data_q <= {hi_q, i_RX_DATA};
              chk_q       <= chk_q ^ i_RX_DATA;
              cnt_q       <= cnt_inc;
              state_q     <= (cnt_inc == len_q) ? StChk : StDatHi;
            end
          end
          StChk: begin
            if (i_RX_VALID) begin
              ack_q   <= (i_RX_DATA == chk_q);
              state_q <= StReply;
            end
          end
          StReply: begin
            if (!i_TX_BUSY) begin
              tx_start_q <= 1'b1;
              if (ack_q) begin
                tx_data_q   <= AckByte;
                state_q     <= StRun;
                cpu_rst_q   <= 1'b0;
                boot_done_q <= 1'b1;
                err_q       <= 1'b0;
              end else begin
                tx_data_q   <= NakByte;
                state_q     <= StSync;
                boot_done_q <= 1'b0;
                err_q       <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= StSync;
          end
        endcase
      end
    end
  end

  assign o_TX_DATA   = tx_data_q;
  assign o_TX_START  = tx_start_q;
  assign o_CPU_RST   = cpu_rst_q;
  assign o_IMEM_WE   = imem_we_q;
  assign o_IMEM_ADDR = imem_addr_q;
  assign o_IMEM_DATA = imem_data_q;
  assign o_BOOT_DONE = boot_done_q;
  assign o_ERR       = err_q;

endmodule
